ntt_stage_sequencer: RTL and testbench
======================================

# ntt_stage_sequencer

Control sequencer for the in-place NTT over the Fermat prime 65537. On `start`, it walks all LOG_N radix-2 decimation-in-frequency stages and issues one butterfly descriptor per handshake: operand addresses plus a twiddle exponent. It tracks butterflies still in flight in the external butterfly/modulo pipeline and holds a stage barrier until they drain, so a stage never reads data the previous stage has not yet written back.

## Interface
- `LOG_N`, default 8: log2 of transform length N (N = 256); legal 2..16.
- `CNT_W`, default LOG_N: width of the in-flight counter; must hold N/2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a transform; honoured only in IDLE.
- `inverse` in 1: sampled with an accepted `start`; selects the inverse twiddle order.
- `bf_valid` out 1: descriptor valid.
- `bf_ready` in 1: butterfly pipeline accepts the descriptor.
- `addr_a` out LOG_N: upper-leg address.
- `addr_b` out LOG_N: lower-leg address.
- `tw_idx` out LOG_N: twiddle exponent e (ω_N^e).
- `stage` out $clog2(LOG_N+1): current stage number.
- `wb_valid` in 1: one butterfly write-back completed.
- `busy` out 1: transform in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky flag, set when `wb_valid` arrives with in-flight = 0; cleared by an accepted `start`.
- `perf_cycles` out 32: cycle counter (see Configuration).

## Operation
- FSM states:
  - IDLE → ISSUE on `start`.
  - ISSUE → DRAIN when the last butterfly of a stage completes a handshake.
  - DRAIN → ISSUE (next stage) when in-flight = 0, or → DONE after stage LOG_N-1.
  - DONE → IDLE unconditionally.
- Butterfly index k runs 0..N/2-1 per stage s. Derived quantities:
  - half = N >> (s+1); j = k mod half; grp = k >> (LOG_N-1-s)
  - `addr_a` = grp·2·half + j; `addr_b` = `addr_a` + half
  - `tw_idx` = j << s forward; (N − (j << s)) mod N inverse
- k advances only on handshake (`bf_valid` & `bf_ready`).
- In-flight counter:
  - +1 on handshake, −1 on `wb_valid`; both in the same cycle leave it unchanged.
  - With `err` set, the decrement is suppressed (no underflow wrap).
- `busy` = 1 in ISSUE and DRAIN. `done` = 1 only in DONE.
- `start` in any state other than IDLE is ignored, including DONE.
- `inverse` is latched at start; later changes have no effect.
- Reset mid-transform returns to IDLE immediately and clears every counter; no drain.

## Timing
- Reset values:
  - `bf_valid`, `busy`, `done`, `err` = 0
  - `addr_a`, `addr_b`, `tw_idx`, `stage` = 0
  - `perf_cycles` = 0
- All outputs are registered.
- `start` sampled at edge t: `busy` and `bf_valid` high from t+1, first descriptor presented at t+1.
- Throughput is one descriptor per cycle while `bf_ready` = 1.
- While `bf_valid` & !`bf_ready`, all descriptor outputs hold stable.
- Stage boundary:
  - The cycle after the last handshake of a stage, `bf_valid` = 0 (DRAIN), even if in-flight is already 0.
  - The first descriptor of the next stage appears the cycle after DRAIN observes in-flight = 0.
- `stage` increments in the same cycle the next stage's first descriptor appears.
- With `bf_ready` = 1 and write-back latency 0, one stage takes N/2 + 1 cycles. Completion latency from `start` is LOG_N·(N/2+1) + 1 cycles to `done`.

## Configuration
- `NTT_SEQ_PERF_EN` defined:
  - `perf_cycles` clears on an accepted `start`.
  - It increments every cycle `busy` = 1.
  - It holds its value after `done` until the next start.
- `NTT_SEQ_PERF_EN` undefined: `perf_cycles` is tied to 0 and no counter logic is synthesised.

## Test plan
- Forward order, LOG_N=3, `bf_ready`=1, write-back 2 cycles after issue. Required (a,b,tw) sequence:
  - stage 0: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
  - stage 1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
  - stage 2: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
  - `done` pulses exactly once.
- Inverse order, LOG_N=3: stage-0 tw = 0,7,6,5; stage-1 tw = 0,6,0,6; addresses identical to forward.
- Backpressure: toggle `bf_ready` pseudo-randomly. Descriptors are stable during stalls, none are skipped or duplicated, and exactly 12 handshakes occur.
- Stage barrier: hold `wb_valid` low for 20 cycles after the stage-0 issues. `bf_valid` stays 0 until the 4th write-back, then (0,2,0) appears one cycle later.
- Error and reset:
  - `wb_valid` while IDLE sets `err`=1; it stays set until the next `start`.
  - `rst_n` low mid-stage-1: all outputs are at reset values asynchronously, and a new `start` restarts from (0,4,0).
- Perf (`NTT_SEQ_PERF_EN`): with LOG_N=3, zero-latency write-back and `bf_ready`=1, `perf_cycles` = 15 at `done`.

Source files
------------

// File: rtl/ntt_stage_sequencer_if.sv
// Butterfly descriptor / write-back channel between the NTT stage sequencer
// and the external butterfly + modulo pipeline. The sequencer is the master.
interface ntt_stage_sequencer_if #(
    parameter int LOG_N = 8
);
    logic             bf_valid;
    logic             bf_ready;
    logic [LOG_N-1:0] addr_a;
    logic [LOG_N-1:0] addr_b;
    logic [LOG_N-1:0] tw_idx;
    logic             wb_valid;

    modport master (
        output bf_valid, addr_a, addr_b, tw_idx,
        input  bf_ready, wb_valid
    );

    modport slave (
        input  bf_valid, addr_a, addr_b, tw_idx,
        output bf_ready, wb_valid
    );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// NTT stage sequencer (radix-2 DIF, in place, modulus 65537).
// Walks LOG_N stages of N/2 butterflies, issuing one descriptor per handshake,
// and holds a barrier between stages until every issued butterfly has been
// written back. Optional cycle counter: define NTT_SEQ_PERF_EN to enable
// perf_cycles; otherwise it is tied to zero.
module ntt_stage_sequencer #(
    parameter int LOG_N = 8,
    parameter int CNT_W = LOG_N
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         inverse,
    ntt_stage_sequencer_if.master        bf,
    output logic [$clog2(LOG_N+1)-1:0]   stage,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  perf_cycles
);
    localparam int SW = $clog2(LOG_N + 1);
    localparam logic [LOG_N-1:0] K_LAST     = {1'b0, {(LOG_N-1){1'b1}}};
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG_N - 32'd1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic [LOG_N-1:0] a;
        logic [LOG_N-1:0] b;
        logic [LOG_N-1:0] tw;
    } desc_t;

    // Butterfly k of stage s: legs grp*2*half + j and +half, twiddle j << s
    // (negated modulo N for the inverse transform).
    function automatic desc_t desc_f(input logic [SW-1:0] s, input logic [LOG_N-1:0] k,
                                     input logic inv);
        desc_t            d;
        logic [SW-1:0]    sh;
        logic [LOG_N-1:0] half;
        logic [LOG_N-1:0] j;
        logic [LOG_N-1:0] grp;
        logic [LOG_N-1:0] jt;
        sh   = LAST_STAGE - s;
        half = LOG_N'(1'b1) << sh;
        j    = k & (half - LOG_N'(1'b1));
        grp  = k >> sh;
        d.a  = (grp << (sh + SW'(1'b1))) | j;
        d.b  = d.a + half;
        jt   = j << s;
        d.tw = inv ? (LOG_N'(1'b0) - jt) : jt;
        return d;
    endfunction

    state_t           state_r, state_n;
    logic [LOG_N-1:0] k_r, k_n;
    logic [SW-1:0]    stage_r, stage_n;
    desc_t            desc_r, desc_n;
    logic             inv_r, inv_n;
    logic             err_r, err_n;
    logic [CNT_W-1:0] inflight_r, inflight_n;
    logic             busy_r, done_r;
    logic             hs_s, start_acc_s, drain_done_s;

    assign hs_s        = bf.bf_valid & bf.bf_ready;
    assign start_acc_s = (state_r == IDLE) & start;
    // The last outstanding write-back releases the barrier in its own cycle.
    assign drain_done_s = (inflight_r == {CNT_W{1'b0}}) ||
                          ((inflight_r == CNT_W'(1'b1)) && bf.wb_valid && !err_r);

    // Next-state, descriptor, in-flight and error computation
    always_comb begin
        state_n    = state_r;
        k_n        = k_r;
        stage_n    = stage_r;
        desc_n     = desc_r;
        inv_n      = inv_r;
        err_n      = err_r;
        inflight_n = inflight_r;

        case ({hs_s, bf.wb_valid})
            2'b10: inflight_n = inflight_r + CNT_W'(1'b1);
            2'b01: begin
                if (!err_r && (inflight_r != {CNT_W{1'b0}})) begin
                    inflight_n = inflight_r - CNT_W'(1'b1);
                end else begin
                    inflight_n = inflight_r;
                end
            end
            default: inflight_n = inflight_r;
        endcase

        // A write-back with nothing outstanding is a protocol error.
        if (bf.wb_valid && !hs_s && (inflight_r == {CNT_W{1'b0}})) begin
            err_n = 1'b1;
        end else begin
            err_n = err_r;
        end

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n    = ISSUE;
                    k_n        = {LOG_N{1'b0}};
                    stage_n    = {SW{1'b0}};
                    inv_n      = inverse;
                    err_n      = 1'b0;
                    inflight_n = {CNT_W{1'b0}};
                    desc_n     = desc_f({SW{1'b0}}, {LOG_N{1'b0}}, inverse);
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (hs_s) begin
                    if (k_r == K_LAST) begin
                        state_n = DRAIN;
                    end else begin
                        k_n    = k_r + LOG_N'(1'b1);
                        desc_n = desc_f(stage_r, k_r + LOG_N'(1'b1), inv_r);
                    end
                end else begin
                    state_n = ISSUE;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    if (stage_r == LAST_STAGE) begin
                        state_n = DONE;
                    end else begin
                        state_n = ISSUE;
                        stage_n = stage_r + SW'(1'b1);
                        k_n     = {LOG_N{1'b0}};
                        desc_n  = desc_f(stage_r + SW'(1'b1), {LOG_N{1'b0}}, inv_r);
                    end
                end else begin
                    state_n = DRAIN;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            k_r         <= {LOG_N{1'b0}};
            stage_r     <= {SW{1'b0}};
            desc_r      <= '{a: {LOG_N{1'b0}}, b: {LOG_N{1'b0}}, tw: {LOG_N{1'b0}}};
            inv_r       <= 1'b0;
            err_r       <= 1'b0;
            inflight_r  <= {CNT_W{1'b0}};
            bf.bf_valid <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            k_r         <= k_n;
            stage_r     <= stage_n;
            desc_r      <= desc_n;
            inv_r       <= inv_n;
            err_r       <= err_n;
            inflight_r  <= inflight_n;
            bf.bf_valid <= (state_n == ISSUE);
            busy_r      <= (state_n == ISSUE) || (state_n == DRAIN);
            done_r      <= (state_n == DONE);
        end
    end

    assign bf.addr_a = desc_r.a;
    assign bf.addr_b = desc_r.b;
    assign bf.tw_idx = desc_r.tw;
    assign stage     = stage_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

`ifdef NTT_SEQ_PERF_EN
    logic [31:0] perf_r;

    // Busy-cycle counter: cleared by an accepted start, frozen while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 32'd0;
        end else if (start_acc_s) begin
            perf_r <= 32'd0;
        end else if (busy_r) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_cycles = perf_r;
`else
    assign perf_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer at LOG_N = 3 (N = 8).
module tb_ntt_stage_sequencer;
    localparam int LOG_N = 3;
    localparam int SW    = $clog2(LOG_N + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          inverse = 1'b0;
    logic [SW-1:0] stage;
    logic          busy, done, err;
    logic [31:0]   perf_cycles;

    ntt_stage_sequencer_if #(.LOG_N(LOG_N)) bfi ();

    ntt_stage_sequencer #(.LOG_N(LOG_N), .CNT_W(LOG_N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .inverse     (inverse),
        .bf          (bfi.master),
        .stage       (stage),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] tw;
    } vec_t;

    vec_t        tbl[24];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] hist   = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of pipeline inputs; write-back returns lat cycles after issue.
    task automatic drive(input logic rdy, input int lat, output logic hs);
        bfi.bf_ready = rdy;
        hs           = bfi.bf_valid & rdy;
        hist         = {hist[14:0], hs};
        bfi.wb_valid = hist[lat];
    endtask

    task automatic run_transform(input logic inv, input int lat, input bit rnd,
                                 output int done_at, output logic [31:0] perf_d);
        int         n_hs, n_done, cyc, base;
        logic       hs, rdy, stalled;
        logic [8:0] prev;
        vec_t       e;
        base    = inv ? 12 : 0;
        hist    = 16'd0;
        n_hs    = 0;
        n_done  = 0;
        done_at = -1;
        perf_d  = 32'hdead_beef;
        stalled = 1'b0;
        prev    = 9'd0;
        start   = 1'b1;
        inverse = inv;
        drive(1'b1, lat, hs);
        tick();
        start   = 1'b0;
        inverse = ~inv;
        cyc     = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_after_start", 32'(bfi.bf_valid), 32'd1);
        check("err_after_start", 32'(err), 32'd0);
        while (cyc < 400 && (done_at < 0 || cyc < done_at + 3)) begin
            if (stalled) begin
                check("stall_hold", 32'({bfi.addr_a, bfi.addr_b, bfi.tw_idx}), 32'(prev));
            end
            if (done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = cyc;
                    perf_d  = perf_cycles;
                end
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(rdy, lat, hs);
            if (hs) begin
                if (n_hs < 12) begin
                    e = tbl[base + n_hs];
                    check($sformatf("desc[%0d]", base + n_hs),
                          32'({stage, bfi.addr_a, bfi.addr_b, bfi.tw_idx}),
                          32'({e.st, e.a, e.b, e.tw}));
                end
                n_hs++;
            end
            stalled = bfi.bf_valid & ~rdy;
            prev    = {bfi.addr_a, bfi.addr_b, bfi.tw_idx};
            tick();
            cyc++;
            if (done_at >= 0 && cyc == done_at + 1) begin
                check("start_ignored_in_done", 32'(busy), 32'd0);
            end
        end
        start        = 1'b0;
        bfi.wb_valid = 1'b0;
        hist         = 16'd0;
        check("done_seen", 32'(done_at >= 0), 32'd1);
        check("handshakes", 32'(n_hs), 32'd12);
        check("done_pulses", 32'(n_done), 32'd1);
    endtask

    initial begin : main
        int          fa[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
        int          fb[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
        int          ftw[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
        int          itw[12] = '{0, 7, 6, 5, 0, 6, 0, 6, 0, 0, 0, 0};
        int          d_at, n;
        logic [31:0] pf;
        logic        hs;

        for (int i = 0; i < 12; i++) begin
            tbl[i]      = '{st: 2'(i / 4), a: 3'(fa[i]), b: 3'(fb[i]), tw: 3'(ftw[i])};
            tbl[i + 12] = '{st: 2'(i / 4), a: 3'(fa[i]), b: 3'(fb[i]), tw: 3'(itw[i])};
        end

        bfi.bf_ready = 1'b0;
        bfi.wb_valid = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              32'({bfi.bf_valid, busy, done, err, stage, bfi.addr_a, bfi.addr_b, bfi.tw_idx}),
              32'd0);
        check("reset_perf", perf_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Stray write-back while idle: sticky error until the next start
        bfi.wb_valid = 1'b1;
        tick();
        bfi.wb_valid = 1'b0;
        check("err_set", 32'(err), 32'd1);
        repeat (5) tick();
        check("err_sticky", 32'(err), 32'd1);

        run_transform(1'b0, 2, 1'b0, d_at, pf);
        run_transform(1'b1, 2, 1'b0, d_at, pf);
        run_transform(1'b0, 2, 1'b1, d_at, pf);
        run_transform(1'b0, 0, 1'b0, d_at, pf);
        check("done_latency", 32'(d_at), 32'd16);
`ifdef NTT_SEQ_PERF_EN
        check("perf_at_done", pf, 32'd15);
`else
        check("perf_tied_zero", pf, 32'd0);
`endif

        // Stage barrier: no write-backs for 20 cycles after stage 0 issues
        start = 1'b1;
        inverse = 1'b0;
        bfi.bf_ready = 1'b1;
        bfi.wb_valid = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("barrier_hold[%0d]", i), 32'(bfi.bf_valid), 32'd0);
            tick();
        end
        bfi.wb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("barrier_wb[%0d]", i), 32'(bfi.bf_valid), 32'd0);
            tick();
        end
        bfi.wb_valid = 1'b0;
        check("barrier_release",
              32'({bfi.bf_valid, stage, bfi.addr_a, bfi.addr_b, bfi.tw_idx}),
              32'({1'b1, 2'd1, 3'd0, 3'd2, 3'd0}));
        hist = 16'd0;
        n = 0;
        while (n < 60 && !done) begin
            drive(1'b1, 0, hs);
            tick();
            n++;
        end
        check("barrier_run_done", 32'(done), 32'd1);
        bfi.wb_valid = 1'b0;
        tick();

        // Asynchronous reset in the middle of stage 1
        start = 1'b1;
        hist = 16'd0;
        drive(1'b1, 2, hs);
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            drive(1'b1, 2, hs);
            if (hs) n++;
            tick();
        end
        check("pre_reset_stage", 32'(stage), 32'd1);
        bfi.wb_valid = 1'b0;
        bfi.bf_ready = 1'b0;
        hist = 16'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({bfi.bf_valid, busy, done, err, stage, bfi.addr_a, bfi.addr_b, bfi.tw_idx}),
              32'd0);
        check("async_reset_perf", perf_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_transform(1'b0, 2, 1'b0, d_at, pf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
